// File: rtl/sim_ctrl_mmio.sv
// Simulation-control peripheral on the CPU data bus.
// Turns firmware stores into pass/fail status, console bytes, a cycle count
// and a firmware-armed watchdog so hex tests can end themselves.
module sim_ctrl_mmio #(
    parameter int unsigned CPU_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    // CPU bus
    input  logic                  bus_valid,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [CPU_WIDTH-1:0]  bus_wdata,
    output logic                  bus_ready,
    output logic [CPU_WIDTH-1:0]  bus_rdata,
    output logic                  bus_rvalid,
    // Console byte stream towards the bench
    output logic                  con_valid,
    output logic [7:0]            con_data,
    input  logic                  con_ready,
    // Test status
    output logic                  test_done,
    output logic                  test_pass,
    output logic [CPU_WIDTH-2:0]  fail_code,
    output logic                  wd_timeout,
    output logic [CPU_WIDTH-1:0]  cycle_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_TOHOST  = ADDR_WIDTH'(4'h0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CONSOLE = ADDR_WIDTH'(4'h4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CYCLE   = ADDR_WIDTH'(4'h8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_WDOG    = ADDR_WIDTH'(4'hC);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StPass    = 2'd1,
        StFail    = 2'd2,
        StTimeout = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e                r_state;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timeout;
    logic [CPU_WIDTH-2:0]  r_fail_code;
    logic [CPU_WIDTH-1:0]  r_cycle;
    logic [CPU_WIDTH-1:0]  r_wdog;
    logic [CPU_WIDTH-1:0]  r_rdata;
    logic                  r_rvalid;
    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_e                w_state_d;
    logic                  w_sel_tohost;
    logic                  w_sel_console;
    logic                  w_sel_cycle;
    logic                  w_sel_wdog;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_run;
    logic                  w_tohost_act;
    logic                  w_wdog_load;
    logic                  w_wdog_expire;
    logic                  w_push;
    logic                  w_pop;
    logic [CPU_WIDTH-1:0]  w_rdata_d;

    // Full address compare: misaligned offsets fall out as unmapped.
    assign w_sel_tohost  = (bus_addr == ADDR_TOHOST);
    assign w_sel_console = (bus_addr == ADDR_CONSOLE);
    assign w_sel_cycle   = (bus_addr == ADDR_CYCLE);
    assign w_sel_wdog    = (bus_addr == ADDR_WDOG);

    assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);

    // Only a console write into a full FIFO stalls; no same-cycle pop bypass.
    assign w_ready  = ~(bus_we & w_sel_console & w_fifo_full);
    assign w_accept = bus_valid & w_ready;
    assign w_wr     = w_accept & bus_we;
    assign w_rd     = w_accept & ~bus_we;

    assign w_run = (r_state == StRun);

    // Even TOHOST values are ignored; odd ones end the test.
    assign w_tohost_act = w_wr & w_sel_tohost & w_run & bus_wdata[0];

    // WDOG writes only take effect while running.
    assign w_wdog_load = w_wr & w_sel_wdog & w_run;

    // A load in the same cycle overrides the decrement, hence no expiry.
    assign w_wdog_expire = w_run & ~w_wdog_load & (r_wdog == CPU_WIDTH'(1));

    // Console pushes continue in terminal states so the FIFO can drain.
    assign w_push = w_wr & w_sel_console;
    assign w_pop  = ~w_fifo_empty & con_ready;

    // ------------------------------------------------------------------
    // Test-status FSM
    // ------------------------------------------------------------------

    // Next-state: TOHOST takes precedence over a coincident watchdog expiry.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StRun: begin
                if (w_tohost_act) begin
                    w_state_d = (bus_wdata == CPU_WIDTH'(1)) ? StPass : StFail;
                end else if (w_wdog_expire) begin
                    w_state_d = StTimeout;
                end
            end
            default: w_state_d = r_state;
        endcase
    end

    // State register plus registered status outputs derived from next state.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_state     <= StRun;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_code <= '0;
        end else begin
            r_state   <= w_state_d;
            r_done    <= (w_state_d != StRun);
            r_pass    <= (w_state_d == StPass);
            r_timeout <= (w_state_d == StTimeout);
            if (w_run && (w_state_d == StFail)) begin
                r_fail_code <= bus_wdata[CPU_WIDTH-1:1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and watchdog
    // ------------------------------------------------------------------

    // Count while running; the transition cycle still counts, then freeze.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_cycle <= '0;
        end else if (w_run) begin
            r_cycle <= r_cycle + CPU_WIDTH'(1);
        end
    end

    // Watchdog: load on write (0 disables), else count down while running.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_wdog <= '0;
        end else if (w_wdog_load) begin
            r_wdog <= bus_wdata;
        end else if (w_run && (r_wdog != '0)) begin
            r_wdog <= r_wdog - CPU_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Read mux; write-only and unmapped locations read as zero.
    always_comb begin
        w_rdata_d = '0;
        if (w_sel_cycle) begin
            w_rdata_d = r_cycle;
        end else if (w_sel_wdog) begin
            w_rdata_d = r_wdog;
        end
    end

    // Registered read response: one-cycle rvalid, rdata holds between reads.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------

    // Storage array; no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus_wdata[7:0];
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_ready   = w_ready;
    assign bus_rdata   = r_rdata;
    assign bus_rvalid  = r_rvalid;
    assign con_valid   = ~w_fifo_empty;
    // Masked when empty so stale bytes never show after a reset.
    assign con_data    = w_fifo_empty ? 8'h00 : r_mem[r_rptr];
    assign test_done   = r_done;
    assign test_pass   = r_pass;
    assign fail_code   = r_fail_code;
    assign wd_timeout  = r_timeout;
    assign cycle_count = r_cycle;

endmodule
